// File: rtl/apb_master_bridge_if.sv
// Bundle of the requester-side handshake and the APB bus driven by apb_master_bridge.
// The master modport is the bridge's view; slave is the view of whatever sits around it.
interface apb_master_bridge_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_error,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_error,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY
  );

endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: one CPU load/store becomes one SETUP/ACCESS transfer,
// with a wait-state timeout so a silent slave cannot stall the requester forever.
module apb_master_bridge #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  apb_master_bridge_if.master  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic             TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             psel_q,      psel_d;
  logic             penable_q,   penable_d;
  logic             pwrite_q,    pwrite_d;
  logic [31:0]      paddr_q,     paddr_d;
  logic [31:0]      pwdata_q,    pwdata_d;
  logic [3:0]       pstrb_q,     pstrb_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_error_q, rsp_error_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;

  // Ready is the only combinational output; gating by PRESETn keeps it low through reset.
  assign bus.req_ready = (state_q == IDLE) && PRESETn;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = rsp_error_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          paddr_d   = bus.req_addr;
          pwrite_d  = bus.req_write;
          pwdata_d  = bus.req_write ? bus.req_wdata : '0;
          pstrb_d   = bus.req_write ? bus.req_strb  : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // PREADY is tested first so a completion on the expiry edge is not an error.
        if (bus.PREADY) begin
          rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
          rsp_error_d = 1'b0;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = RESP;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          rsp_rdata_d = '0;
          rsp_error_d = 1'b1;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSTRB     = pstrb_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Single-outstanding APB master that turns simple CPU-side load/store requests into APB SETUP/ACCESS transfers. It drives the peripheral bus (PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB) that the GPIO slave and other APB slaves decode. It returns read data or a timeout error to the requester. One transfer is in flight at a time, and a wait-state timeout counter guarantees forward progress when a slave never raises PREADY.

## Interface
Parameters:
- TIMEOUT, 16, max ACCESS cycles waited for PREADY; 0 disables the timeout
- CNT_W, 8, timeout counter width; TIMEOUT must be < 2^CNT_W

Ports:
- PCLK  in  1  single clock, all state on rising edge
- PRESETn  in  1  reset; synchronous, active-low
- req_valid  in  1  requester has a transfer
- req_ready  out  1  bridge accepts; transfer taken when req_valid && req_ready at a rising edge
- req_write  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_strb  in  4  byte-lane strobes (writes)
- rsp_valid  out  1  one-cycle pulse: transfer finished
- rsp_rdata  out  32  read data; 0 for writes and for errors
- rsp_error  out  1  qualified by rsp_valid; 1 = timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  32  APB address
- PWDATA  out  32  APB write data
- PSTRB  out  4  APB strobes
- PRDATA  in  32  slave read data
- PREADY  in  1  slave completion

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE
  - req_ready = 1. This is the only state with req_ready high, and req_ready is 0 while PRESETn = 0.
  - On accept: latch req_* into PADDR, PWRITE, PWDATA, PSTRB. For a read, PSTRB = 4'b0000 and PWDATA = 0.
  - Go to SETUP.
- SETUP
  - PSEL = 1, PENABLE = 0.
  - Go to ACCESS unconditionally; clear the timeout counter.
- ACCESS
  - PSEL = 1, PENABLE = 1. PADDR, PWRITE, PWDATA and PSTRB stay stable.
  - PREADY = 1 at an edge: capture PRDATA into rsp_rdata if reading (else 0), set rsp_error = 0, go to RESP.
  - Else, if TIMEOUT != 0 and counter == TIMEOUT-1: set rsp_rdata = 0, rsp_error = 1, go to RESP.
  - Else increment the counter.
  - PREADY high on the same edge the timeout expires: PREADY wins, no error.
- RESP
  - PSEL = 0, PENABLE = 0, rsp_valid = 1 for exactly this cycle.
  - Go to IDLE. There is no response backpressure.
- PREADY is ignored in IDLE, SETUP and RESP.
- All outputs except req_ready are registered.
- Reset values: PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA, PRDATA-capture = 0; PSTRB = 0; rsp_valid, rsp_error = 0; rsp_rdata = 0; state IDLE; counter 0.
- Reset during SETUP or ACCESS:
  - The bus drops to idle on the reset edge and the transfer is discarded.
  - No rsp_valid is generated for it.
  - After reset, the bridge is ready in the first cycle that PRESETn = 1.

## Timing
- Accept at edge E0.
  - SETUP occupies cycle E0–E1.
  - ACCESS starts at E1.
- Zero-wait slave (PREADY = 1 sampled at E2): rsp_valid high in cycle E2–E3. That is 3 cycles from accept to response.
- Each wait state adds 1 cycle.
- Timeout, with PREADY stuck low: rsp_valid is asserted TIMEOUT+2 cycles after accept.
- Back-to-back requests: the next accept happens at the earliest at the edge ending RESP plus 1, because IDLE must be entered. Minimum period is 4 cycles per transfer.
- The PSEL rising edge always precedes the PENABLE rising edge by exactly 1 cycle. Both fall together.

## Test plan
- Reset, then write: addr 0x00000000, wdata 0x000000F0, strb 4'b0001, zero-wait slave.
  - Expect PSEL at cycle 1, PENABLE at cycle 2, PSTRB = 0001, PWDATA = 0x000000F0.
  - Expect rsp_valid at cycle 3 with rsp_error = 0 and rsp_rdata = 0.
- Read: addr 0xFFFFFFFF, slave returns PRDATA = 0x0000000F with 1 wait state.
  - Expect PSTRB = 0000 and ACCESS lasting 2 cycles.
  - Expect rsp_rdata = 0x0000000F and rsp_valid at cycle 4.
- Timeout: TIMEOUT = 16, PREADY held 0.
  - Expect exactly 16 ACCESS cycles, then rsp_valid with rsp_error = 1 and rsp_rdata = 0.
  - Expect PSEL and PENABLE low in RESP.
- PREADY rises on the 16th ACCESS cycle: expect rsp_error = 0 and PRDATA captured.
- Reset mid-ACCESS (PRESETn low for 1 edge):
  - Expect PSEL and PENABLE = 0 at the next cycle and no rsp_valid.
  - Expect req_ready = 1 once PRESETn is high.
- Back-to-back: req_valid held high with two writes.
  - Expect accepts 4 cycles apart and PADDR stable throughout each ACCESS.
  - Expect req_ready = 0 in SETUP, ACCESS and RESP.
